// File: rtl/keccak_digest_ser.sv
// keccak_digest_ser
//   Takes the 25-lane final Keccak state pushed by the round engine and keeps
//   the first OUT_LANES lanes. It sends those lanes out as a byte stream: lane 0
//   bits [7:0] come first and lane OUT_LANES-1 bits [63:56] come last. Two
//   ping-pong banks let the next state be captured while the previous digest
//   is still draining.
//
// Ports
//   clk, rst  : clock and synchronous active-high reset
//   pushin    : lane valid from the round engine
//   firstin   : qualifies pushin; this lane is lane 0 of a new state
//   din       : 64-bit lane data
//   stopin    : registered; 1 when no bank is free (one-cycle skid is tolerated)
//   dout      : digest byte, forced to 0 while pushout=0
//   pushout   : dout is valid
//   firstout  : first byte of a digest (qualified by pushout)
//   lastout   : last byte of a digest (qualified by pushout)
//   stopout   : downstream stall; a byte transfers when pushout=1 and stopout=0
//   overrun   : sticky until rst; a whole state was dropped for lack of a bank
module keccak_digest_ser #(
  parameter int unsigned OUT_LANES = 4,
  parameter int unsigned NLANES    = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic        firstin,
  input  logic [63:0] din,
  output logic        stopin,
  output logic [7:0]  dout,
  output logic        pushout,
  output logic        firstout,
  output logic        lastout,
  input  logic        stopout,
  output logic        overrun
);

  localparam int unsigned OUT_BYTES = 8 * OUT_LANES;
  localparam int unsigned BCW       = $clog2(OUT_BYTES);
  localparam int unsigned DW        = OUT_BYTES * 8;

  localparam logic [BCW-1:0] LAST_BYTE  = BCW'(OUT_BYTES - 1);
  localparam logic [4:0]     OUT_LANES5 = 5'(OUT_LANES);
  localparam logic [4:0]     LAST_KEEP  = 5'(OUT_LANES - 1);
  localparam logic [4:0]     LAST_LANE  = 5'(NLANES - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_SENDING
  } bank_st_e;

  bank_st_e        bank_st_q   [2];
  bank_st_e        bank_st_d   [2];
  logic [DW-1:0]   bank_data_q [2];
  logic [DW-1:0]   bank_data_d [2];

  logic            wr_ptr_q,   wr_ptr_d;
  logic            rd_ptr_q,   rd_ptr_d;
  logic            cap_bank_q, cap_bank_d;
  logic [4:0]      lane_cnt_q, lane_cnt_d;
  logic            drop_q,     drop_d;
  logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
  logic            stopin_q,   stopin_d;
  logic            overrun_q,  overrun_d;

  logic [DW-1:0]   rd_shift;
  logic            out_valid;
  logic            xfer;
  logic            can_alloc;

  always_comb begin
    bank_st_d   = bank_st_q;
    bank_data_d = bank_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cap_bank_d  = cap_bank_q;
    lane_cnt_d  = lane_cnt_q;
    drop_d      = drop_q;
    byte_cnt_d  = byte_cnt_q;
    overrun_d   = overrun_q;
    can_alloc   = 1'b0;

    // The output is driven straight from the bank at rd ptr. This way a bank
    // that goes FULL on an edge presents byte 0 right after that edge, and a
    // stall holds every output with no extra holding register.
    out_valid = (bank_st_q[rd_ptr_q] == BANK_FULL) ||
                (bank_st_q[rd_ptr_q] == BANK_SENDING);
    rd_shift  = bank_data_q[rd_ptr_q] >> {byte_cnt_q, 3'b000};
    xfer      = out_valid && !stopout;

    if (xfer) begin
      if (byte_cnt_q == LAST_BYTE) begin
        bank_st_d[rd_ptr_q] = BANK_EMPTY;
        rd_ptr_d            = ~rd_ptr_q;
        byte_cnt_d          = '0;
      end else begin
        bank_st_d[rd_ptr_q] = BANK_SENDING;
        byte_cnt_d          = byte_cnt_q + 1'b1;
      end
    end

    // Allocation looks at the post-drain bank state. A bank freed by this
    // cycle's last-byte transfer can therefore take a firstin in the same
    // cycle. A FILLING bank at wr ptr is always the state that is currently
    // active, so a restart reuses it.
    if (pushin) begin
      if (firstin) begin
        can_alloc = (bank_st_d[wr_ptr_q] == BANK_EMPTY) ||
                    (bank_st_d[wr_ptr_q] == BANK_FILLING);
        lane_cnt_d = 5'd1;
        if (can_alloc) begin
          drop_d                          = 1'b0;
          cap_bank_d                      = wr_ptr_q;
          bank_data_d[wr_ptr_q][63:0]     = din;
          if (OUT_LANES == 1) begin
            bank_st_d[wr_ptr_q] = BANK_FULL;
            wr_ptr_d            = ~wr_ptr_q;
          end else begin
            bank_st_d[wr_ptr_q] = BANK_FILLING;
          end
        end else begin
          drop_d    = 1'b1;
          overrun_d = 1'b1;
        end
      end else if (lane_cnt_q != 5'd0) begin
        lane_cnt_d = (lane_cnt_q == LAST_LANE) ? 5'd0 : lane_cnt_q + 5'd1;
        if (!drop_q && (lane_cnt_q < OUT_LANES5)) begin
          for (int unsigned l = 1; l < OUT_LANES; l++) begin
            if (lane_cnt_q == 5'(l)) begin
              bank_data_d[cap_bank_q][l*64 +: 64] = din;
            end
          end
          if (lane_cnt_q == LAST_KEEP) begin
            bank_st_d[cap_bank_q] = BANK_FULL;
            wr_ptr_d              = ~wr_ptr_q;
          end
        end
      end
    end

    stopin_d = (bank_st_d[0] != BANK_EMPTY) && (bank_st_d[1] != BANK_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      cap_bank_q   <= 1'b0;
      lane_cnt_q   <= '0;
      drop_q       <= 1'b0;
      byte_cnt_q   <= '0;
      stopin_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bank_st_q    <= bank_st_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cap_bank_q   <= cap_bank_d;
      lane_cnt_q   <= lane_cnt_d;
      drop_q       <= drop_d;
      byte_cnt_q   <= byte_cnt_d;
      stopin_q     <= stopin_d;
      overrun_q    <= overrun_d;
    end
  end

  // Bank payload needs no reset: it is only read while its bank is FULL/SENDING.
  always_ff @(posedge clk) begin
    bank_data_q <= bank_data_d;
  end

  always_comb begin
    pushout  = out_valid;
    dout     = out_valid ? rd_shift[7:0] : '0;
    firstout = out_valid && (byte_cnt_q == '0);
    lastout  = out_valid && (byte_cnt_q == LAST_BYTE);
    stopin   = stopin_q;
    overrun  = overrun_q;
  end

endmodule
